// File: rtl/cfg_fetch_pkg.sv
// Shared types and constants for the configuration fetch master and its xbus.
package cfg_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ERR
  } fetch_state_t;

  localparam logic [3:0] XB_BE_ALL    = 4'hF;
  localparam int         XB_MAX_WORDS = 4096;
  localparam int         XB_COUNT_W   = $clog2(XB_MAX_WORDS) + 1;

endpackage

// File: rtl/cfg_fetch_master_if.sv
// xbus request/response bundle between the fetch master and a slave.
interface cfg_fetch_master_if;

  logic        xbs_select;
  logic [31:0] xbs_addr;
  logic [31:0] xbs_data;
  logic        xbs_rnw;
  logic [3:0]  xbs_be;
  logic        sl_ack;
  logic [31:0] sl_data;

  modport master (
    output xbs_select, xbs_addr, xbs_data, xbs_rnw, xbs_be,
    input  sl_ack, sl_data
  );

  modport slave (
    input  xbs_select, xbs_addr, xbs_data, xbs_rnw, xbs_be,
    output sl_ack, sl_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // NOTE: storage has no reset; empty_o masks stale entries, and only the pointers and count need a defined value.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cfg_fetch_master.sv
// Fetches a block of words over xbus, one request outstanding at a time,
// and buffers the read data in a FIFO for a ready/valid consumer.
module cfg_fetch_master
  import cfg_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [31:0]             base_addr,
  input  logic [XB_COUNT_W-1:0]   word_count,
  cfg_fetch_master_if.master      xb,
  output logic                    out_valid,
  output logic [31:0]             out_data,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  fetch_state_t            state_q, state_d;
  logic [31:0]             addr_q, addr_d;
  logic [XB_COUNT_W-1:0]   remaining_q, remaining_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    fifo_push, fifo_pop, fifo_empty, slot_free;
  logic [CW-1:0]           fifo_count;

  // Only one request is ever in flight, so a single free slot guarantees its data a home.
  assign slot_free   = (fifo_count < CW'(FIFO_DEPTH));
  assign out_valid   = !fifo_empty;
  assign fifo_pop    = out_valid && out_ready;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign error       = error_q;
  assign xb.xbs_data = '0;
  assign xb.xbs_rnw  = 1'b1;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    tmo_d         = tmo_q;
    done_d        = 1'b0;
    error_d       = error_q;
    fifo_push     = 1'b0;
    xb.xbs_select = 1'b0;
    xb.xbs_addr   = '0;
    xb.xbs_be     = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = word_count;
          error_d     = 1'b0;
          if (word_count == '0) done_d  = 1'b1;
          else                  state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (slot_free) begin
          xb.xbs_select = 1'b1;
          xb.xbs_addr   = addr_q;
          xb.xbs_be     = XB_BE_ALL;
          tmo_d         = '0;
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (xb.sl_ack) begin
          fifo_push   = 1'b1;
          addr_d      = addr_q + 32'd1;
          remaining_d = remaining_q - XB_COUNT_W'(1);
          if (remaining_q == XB_COUNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_REQ;
          end
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      tmo_q       <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      tmo_q       <= tmo_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (fifo_push),
    .push_data_i (xb.sl_data),
    .pop_i       (fifo_pop),
    .head_o      (out_data),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule
